// File: rtl/gf_int_divider.sv
// gf_int_divider: iterative bit-serial divider, one quotient bit per clock.
//
// Computes quotient and remainder of two WIDTH-bit operands in one of two modes,
// chosen per operation by gf_option:
//   0 - unsigned integer division (restoring compare-and-subtract)
//   1 - GF(2) polynomial division (carry-less subtract, i.e. XOR)
//
// Compile-time option: define GF_DIV_GF_MODE_EN to build the GF(2) datapath.
// Without it gf_option is ignored and every operation is integer division;
// timing is identical in both builds.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   start       in   request, accepted only in idle
//   gf_option   in   mode, captured with start
//   a, b        in   dividend / divisor, captured with start
//   busy        out  operation in progress (run and finish states)
//   done        out  one-cycle pulse, results valid
//   quotient    out  held until the next accepted start
//   remainder   out  held until the next accepted start
//   div_by_zero out  captured divisor was zero; held like the results
module gf_int_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gf_option,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  state_e r_state, w_state_next;

  // r_a shifts left each step so its MSB is always the next dividend bit.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  // Between steps the partial remainder is always below the divisor, so only
  // WIDTH bits are stored; the WIDTH+1-bit value exists only after the shift.
  logic [WIDTH-1:0] r_rem;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_int_take;
  logic             w_take;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  logic             w_unused;

`ifdef GF_DIV_GF_MODE_EN
  logic             r_gf;
  logic [CntW-1:0]  r_deg;
  logic [CntW-1:0]  w_deg;
  logic [WIDTH-1:0] w_shift_lo;
  logic             w_gf_take;

  // Degree of the divisor polynomial: index of its highest set bit.
  always_comb begin
    w_deg = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (b[i]) w_deg = CntW'(i);
    end
  end

  assign w_shift_lo = w_shift[WIDTH-1:0];
  assign w_gf_take  = w_shift_lo[r_deg];
  // Remainder degree stays below deg(b) <= WIDTH-1, so bit WIDTH of the shifted
  // value is always zero in GF mode.
  assign w_unused   = w_diff[WIDTH];
`else
  assign w_unused   = w_diff[WIDTH] ^ gf_option;
`endif

  // One iteration: bring in the next dividend bit, then try to subtract.
  assign w_shift    = {r_rem, r_a[WIDTH-1]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_b};
  assign w_int_take = ~w_diff[WIDTH+1];

  always_comb begin
    w_take     = w_int_take;
    w_rem_next = w_int_take ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
`ifdef GF_DIV_GF_MODE_EN
    if (r_gf) begin
      w_take     = w_gf_take;
      w_rem_next = w_gf_take ? (w_shift[WIDTH-1:0] ^ r_b) : w_shift[WIDTH-1:0];
    end
`endif
  end

  assign w_q_next = (r_q << 1) | WIDTH'(w_take);
  assign w_last   = (r_cnt == CntW'(WIDTH - 1));

  // FSM next state and status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start) w_state_next = (b == '0) ? StFin : StRun;
      end
      StRun: begin
        if (w_last) w_state_next = StFin;
      end
      StFin: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a           <= '0;
      r_b           <= '0;
      r_q           <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
`ifdef GF_DIV_GF_MODE_EN
      r_gf          <= 1'b0;
      r_deg         <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_q   <= '0;
            r_rem <= '0;
            r_cnt <= '0;
`ifdef GF_DIV_GF_MODE_EN
            r_gf  <= gf_option;
            r_deg <= w_deg;
`endif
            // Divide by zero skips the iterations and publishes immediately.
            if (b == '0) begin
              r_quotient    <= '1;
              r_remainder   <= a;
              r_div_by_zero <= 1'b1;
            end
          end
        end
        StRun: begin
          r_a   <= r_a << 1;
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CntW'(1);
          if (w_last) begin
            r_quotient    <= w_q_next;
            r_remainder   <= w_rem_next;
            r_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_gf_int_divider.sv
// Self-checking bench for gf_int_divider (WIDTH = 32).
// Results are checked by a monitor that pops a scoreboard queue on every done;
// the main process drives operations and checks timing.
module tb_gf_int_divider;

  localparam int unsigned W = 32;
`ifdef GF_DIV_GF_MODE_EN
  localparam bit GfOn = 1'b1;
`else
  localparam bit GfOn = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         gf;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         gf_option;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  gf_int_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .gf_option  (gf_option),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_done   = 0;
  int   done_cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest pending operation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("div_by_zero", div_by_zero, mon_e.dz);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one operation in the current cycle (cycle 0) and time its done.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic igf,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input int exp_lat);
    int lat;
    a         = ia;
    b         = ib;
    gf_option = igf;
    start     = 1'b1;
    sb.push_back('{eq, er, edz});
    lat = 0;
    for (int k = 1; k <= int'(W) + 8 && lat == 0; k++) begin
      step();
      if (k == 1) begin
        start     = 1'b0;
        // Operands must already be captured; scramble the inputs.
        a         = $urandom;
        b         = $urandom;
        gf_option = ~igf;
        check("busy_cycle1", busy, 1'b1);
      end
      if (done === 1'b1) lat = k;
    end
    check("done_latency", lat, exp_lat);
    step();
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int t0;
    int nd0;
    int lat;

    rst       = 1'b1;
    start     = 1'b0;
    gf_option = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 32'h0);
    check("rst_remainder", remainder, 32'h0);
    check("rst_div_by_zero", div_by_zero, 1'b0);
    rst = 1'b0;
    step();

    vecs[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
    vecs[1]  = '{32'h57, 32'h13, 1'b1, GfOn ? 32'h5 : 32'h4, GfOn ? 32'h8 : 32'hB, 1'b0};
    vecs[2]  = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vecs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0};
    vecs[4]  = '{32'hDEAD_BEEF, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1};
    vecs[5]  = '{32'hDEAD_BEEF, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1};
    vecs[6]  = '{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0};
    vecs[7]  = '{32'd7, 32'd100, 1'b0, 32'd0, 32'd7, 1'b0};
    vecs[8]  = '{32'h8000_0000, 32'd3, 1'b1, GfOn ? 32'h7FFF_FFFF : 32'h2AAA_AAAA,
                 GfOn ? 32'd1 : 32'd2, 1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd1, 32'h7FFF_FFFF, 1'b0};
    vecs[10] = '{32'h1234, 32'd1, 1'b1, 32'h1234, 32'd0, 1'b0};
    vecs[11] = '{32'd12345678, 32'd1000, 1'b0, 32'd12345, 32'd678, 1'b0};

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].gf, vecs[i].q, vecs[i].r, vecs[i].dz,
             (vecs[i].b == '0) ? 1 : int'(W) + 1);
    end

    // Divide by zero, start held through the finish cycle (ignored) into idle.
    a     = 32'hDEAD_BEEF;
    b     = 32'd0;
    gf_option = 1'b0;
    start = 1'b1;
    sb.push_back('{32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1});
    t0 = cyc;
    step();
    check("dbz_done_cycle1", done, 1'b1);
    check("dbz_busy_cycle1", busy, 1'b1);
    a = 32'd9;
    b = 32'd3;
    step();
    check("dbz_busy_cycle2", busy, 1'b0);
    a = 32'd100;
    b = 32'd7;
    sb.push_back('{32'd14, 32'd2, 1'b0});
    step();
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    lat = 0;
    for (int k = 3; k <= 45 && lat == 0; k++) begin
      step();
      if (done === 1'b1) lat = cyc - t0;
    end
    check("b2b_done_cycle", lat, 35);
    step();

    // Start while busy is ignored.
    nd0   = n_done;
    a     = 32'd100;
    b     = 32'd7;
    gf_option = 1'b0;
    start = 1'b1;
    sb.push_back('{32'd14, 32'd2, 1'b0});
    t0 = cyc;
    for (int k = 1; k <= 40; k++) begin
      step();
      start = (k == 10);
      if (k == 10) begin
        a         = 32'd9;
        b         = 32'd3;
        gf_option = 1'b1;
      end
    end
    check("busy_prot_done_count", n_done - nd0, 1);
    check("busy_prot_done_cycle", done_cyc - t0, 33);

    // Reset in the middle of an operation.
    a     = 32'd100;
    b     = 32'd7;
    gf_option = 1'b0;
    start = 1'b1;
    sb.push_back('{32'd14, 32'd2, 1'b0});
    for (int k = 1; k <= 12; k++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_quotient", quotient, 32'h0);
    check("midrst_remainder", remainder, 32'h0);
    check("midrst_div_by_zero", div_by_zero, 1'b0);
    sb.delete();
    nd0 = n_done;
    repeat (2) step();
    rst = 1'b0;
    repeat (40) step();
    check("midrst_no_done", n_done - nd0, 0);
    run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, int'(W) + 1);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gf_int_divider.md
# gf_int_divider

Iterative bit-serial divider for the adder/arithmetic comparison set. It computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock, in one of two modes selected per operation by `gf_option`. In integer mode each step is a restoring compare-and-subtract using a ripple subtract. In GF(2) polynomial mode each step is a carry-less subtract, which is an XOR. It is the inverse-direction companion to the GF/integer adders: they combine operands, this block takes them apart.

## Interface
Parameters:
- `WIDTH`, default 32: operand, quotient and remainder width.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted on a rising edge when `busy`==0.
- `gf_option`  in  1  captured with `start`. 1 = GF(2) polynomial division; 0 = unsigned integer division.
- `a`  in  WIDTH  dividend, captured with `start`.
- `b`  in  WIDTH  divisor, captured with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; results valid.
- `quotient`  out  WIDTH  registered result; held until the next accepted `start`.
- `remainder`  out  WIDTH  registered result; held until the next accepted `start`.
- `div_by_zero`  out  1  set with `done` when captured `b`==0; held like the results.

## Operation
- States: IDLE, RUN, FIN.
  - IDLE + start: capture operands and mode; clear the partial remainder R (WIDTH+1 bits) and the bit counter. If `b`==0, go to FIN; otherwise go to RUN.
  - RUN: performs WIDTH iterations, MSB of `a` first. When the counter reaches WIDTH-1, go to FIN.
  - FIN: pulse `done`; return to IDLE. A `start` arriving in FIN is ignored. `start` is accepted only in IDLE.
- Iteration i (i = WIDTH-1 down to 0): R = {R, a[i]}.
  - Integer mode: if R >= b then R = R - b and q[i] = 1, else q[i] = 0. R needs WIDTH+1 bits because the shift can reach 2b-1.
  - GF mode: d = index of the highest set bit of b, computed at capture and registered. If R[d]==1 then R = R ^ b and q[i] = 1, else q[i] = 0. No borrows.
- On entry to FIN:
  - Normal case: `quotient` = q, `remainder` = R[WIDTH-1:0], `div_by_zero` = 0.
  - Divide by zero, in either mode: `quotient` = all ones, `remainder` = a, `div_by_zero` = 1.
- `start` while `busy` is ignored; captured operands do not change mid-operation.
- `busy` = 1 in RUN and FIN.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, internal R/counter/operands = 0.
- `rst` asserted mid-operation forces these reset values immediately. The operation is abandoned and no `done` is produced.
- `start` high in cycle 0 gives:
  - `busy`=1 from cycle 1.
  - `done`=1 and results updated in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - `busy`=0 from cycle WIDTH+2.
- Divide by zero: `done` in cycle 1.
- Earliest next accepted `start`:
  - normal operation: cycle WIDTH+2;
  - divide by zero: cycle 2.
- Results, `div_by_zero` and `done` all change on the same edge.

## Configuration
- `GF_DIV_GF_MODE_EN` defined: both modes are available as described above.
- `GF_DIV_GF_MODE_EN` undefined:
  - GF datapath (degree encoder, XOR path) is not compiled.
  - `gf_option` port remains but is ignored; every operation is integer division.
  - Timing is unchanged.

## Test plan
- Integer: gf_option=0, a=100, b=7, start in cycle 0 -> quotient=14, remainder=2, div_by_zero=0, `done` in cycle 33 only.
- GF (macro defined): gf_option=1, a=0x57, b=0x13 -> quotient=0x5, remainder=0x8. With the macro undefined, same stimulus -> quotient=4, remainder=0xB.
- Width edge: gf_option=0, a=0xFFFFFFFF, b=1 -> quotient=0xFFFFFFFF, remainder=0. Then a=0xFFFFFFFF, b=0xFFFFFFFF -> quotient=1, remainder=0.
- Divide by zero: a=0xDEADBEEF, b=0, either mode -> quotient=0xFFFFFFFF, remainder=0xDEADBEEF, div_by_zero=1, `done` in cycle 1, `busy` low in cycle 2.
- Busy protection: start a=100, b=7; pulse start with a=9, b=3 in cycle 10 -> still quotient=14, remainder=2 at cycle 33, and only one `done`.
- Reset mid-operation: assert `rst` in cycle 12 of a=100, b=7 -> all outputs 0 immediately, no `done`. After release, start a=50, b=5 -> quotient=10, remainder=0, 33 cycles later.
